// File: rtl/mdio_master.sv
// Clause-22 MDIO initiator: turns one accepted command into a 64-bit read or write frame
// on MDC/MDIO and returns read data plus a turnaround-error flag on a one-cycle strobe.
module mdio_master #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oen,
  input  logic        mdio_i
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFrame = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]      state_q;
  logic [DivW-1:0] div_q;
  logic [5:0]      bit_q;
  logic            high_q;
  logic            first_q;
  logic            write_q;
  logic [63:0]     shift_q;
  logic [15:0]     rd_q;
  logic            ta_q;
  logic            mdc_q;
  logic            mdio_o_q;
  logic            mdio_oen_q;
  logic            rsp_valid_q;
  logic [15:0]     rsp_rdata_q;
  logic            rsp_err_q;

  logic       tick;
  logic       rise;
  logic       fall;
  logic       last;
  logic [5:0] next_bit;

  // first_q marks a virtual high phase so bit 0 starts one cycle after accept.
  always_comb begin
    tick     = (state_q == StFrame) && (div_q == DivLast);
    rise     = tick && !high_q;
    fall     = tick && high_q;
    last     = fall && !first_q && (bit_q == 6'd63);
    next_bit = first_q ? 6'd0 : bit_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      div_q       <= '0;
      bit_q       <= '0;
      high_q      <= 1'b0;
      first_q     <= 1'b0;
      write_q     <= 1'b0;
      shift_q     <= '0;
      rd_q        <= '0;
      ta_q        <= 1'b0;
      mdc_q       <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_oen_q  <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            state_q <= StFrame;
            div_q   <= DivLast;
            high_q  <= 1'b1;
            first_q <= 1'b1;
            bit_q   <= '0;
            write_q <= cmd_write;
            // Read frames carry ones in TA/data; those bits are released, not driven.
            shift_q <= {32'hFFFF_FFFF, 2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr,
                        cmd_reg_addr, cmd_write ? 2'b10 : 2'b11,
                        cmd_write ? cmd_wdata : 16'hFFFF};
          end
        end
        StFrame: begin
          div_q <= tick ? '0 : div_q + DivW'(1);
          if (rise) begin
            mdc_q  <= 1'b1;
            high_q <= 1'b1;
            if (!write_q && (bit_q == 6'd47)) ta_q <= mdio_i;
            if (!write_q && (bit_q >= 6'd48)) rd_q <= {rd_q[14:0], mdio_i};
          end
          if (fall && !last) begin
            mdc_q      <= 1'b0;
            high_q     <= 1'b0;
            first_q    <= 1'b0;
            bit_q      <= next_bit;
            mdio_o_q   <= shift_q[63];
            shift_q    <= {shift_q[62:0], 1'b1};
            mdio_oen_q <= !write_q && (next_bit >= 6'd46);
          end
          if (last) begin
            state_q     <= StDone;
            mdc_q       <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_oen_q  <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= write_q ? 16'h0000 : rd_q;
            rsp_err_q   <= write_q ? 1'b0 : ta_q;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_oen  = mdio_oen_q;

endmodule
